// File: rtl/sdram_mport_sched.sv
// Multi-channel SDRAM transaction scheduler: per-channel wrapping address rings,
// round-robin arbitration over all write/read requesters, one row-bounded burst at a time.
module sdram_mport_sched #(
    parameter int NCH   = 2,
    parameter int AW    = 24,
    parameter int BW    = 2,
    parameter int CW    = 9,
    parameter int BL    = 8,
    parameter int FW    = 8,
    parameter int RD_TH = 128
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [NCH*AW-1:0]     Wr_start,
    input  logic [NCH*AW-1:0]     Wr_max,
    input  logic [NCH-1:0]        Wr_load,
    input  logic [NCH*FW-1:0]     Wr_level,
    input  logic [NCH*AW-1:0]     Rd_start,
    input  logic [NCH*AW-1:0]     Rd_max,
    input  logic [NCH-1:0]        Rd_load,
    input  logic [NCH*FW-1:0]     Rd_level,
    output logic                  Cmd_wr,
    output logic                  Cmd_rd,
    output logic [BW-1:0]         Cmd_baddr,
    output logic [AW-BW-CW-1:0]   Cmd_raddr,
    output logic [CW-1:0]         Cmd_caddr,
    output logic [CW:0]           Cmd_len,
    input  logic                  Cmd_ack,
    input  logic                  Wdata_done,
    input  logic                  Rdata_done,
    output logic [NCH-1:0]        Wr_grant,
    output logic [NCH-1:0]        Rd_grant,
    output logic                  Busy
);
    localparam int RW   = AW - BW - CW;
    localparam int NREQ = 2 * NCH;
    localparam int IW   = $clog2(NREQ);
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   wr_ptr [NCH];
    logic [AW-1:0]   rd_ptr [NCH];
    logic [CW:0]     wr_len [NCH];
    logic [CW:0]     rd_len [NCH];
    logic [NREQ-1:0] req;
    logic [IW-1:0]   rr;
    logic [IW-1:0]   win;
    logic [IW-1:0]   idx;
    logic            found;
    logic            sel_wr;
    logic [CHW-1:0]  sel_ch;
    logic [AW-1:0]   sel_ptr;
    logic [CW:0]     sel_len;
    logic            cur_wr;
    logic [CHW-1:0]  cur_ch;
    logic            done_hit;

    // A burst never runs past the last column of the current row.
    function automatic logic [CW:0] burst_len(input logic [AW-1:0] p);
        logic [CW:0] rem;
        rem = (CW+1)'(1 << CW) - {1'b0, p[CW-1:0]};
        return (rem < (CW+1)'(BL)) ? rem : (CW+1)'(BL);
    endfunction

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p, input logic [CW:0] len,
                                               input logic [AW-1:0] start, input logic [AW-1:0] max);
        logic [AW:0] nxt;
        nxt = {1'b0, p} + (AW+1)'(len);
        return (nxt >= {1'b0, max}) ? start : nxt[AW-1:0];
    endfunction

    always_comb begin
        req = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_len[i] = burst_len(wr_ptr[i]);
            rd_len[i] = burst_len(rd_ptr[i]);
            req[i] = !Wr_load[i]
                     && (Wr_start[i*AW +: AW] != Wr_max[i*AW +: AW])
                     && (int'(Wr_level[i*FW +: FW]) >= int'(wr_len[i]));
            req[NCH+i] = !Rd_load[i]
                         && (Rd_start[i*AW +: AW] != Rd_max[i*AW +: AW])
                         && (int'(Rd_level[i*FW +: FW]) < RD_TH);
        end
    end

    // Round-robin search begins at the entry after the previous winner.
    always_comb begin
        found = 1'b0;
        win   = rr;
        idx   = rr;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(rr) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        sel_wr  = int'(win) < NCH;
        sel_ch  = sel_wr ? CHW'(win) : CHW'(int'(win) - NCH);
        sel_ptr = sel_wr ? wr_ptr[sel_ch] : rd_ptr[sel_ch];
        sel_len = sel_wr ? wr_len[sel_ch] : rd_len[sel_ch];
    end

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done_hit  = 1'b0;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   if (Cmd_ack) state_nxt = WAIT;
            WAIT: begin
                done_hit = cur_wr ? Wdata_done : Rdata_done;
                if (done_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cur_wr    <= 1'b0;
            cur_ch    <= '0;
            rr        <= '0;
            Cmd_baddr <= '0;
            Cmd_raddr <= '0;
            Cmd_caddr <= '0;
            Cmd_len   <= '0;
        end else if (state == IDLE && found) begin
            cur_wr    <= sel_wr;
            cur_ch    <= sel_ch;
            rr        <= IW'((int'(win) + 1) % NREQ);
            Cmd_baddr <= sel_ptr[AW-1 -: BW];
            Cmd_raddr <= sel_ptr[CW +: RW];
            Cmd_caddr <= sel_ptr[CW-1:0];
            Cmd_len   <= sel_len;
        end
    end

    // A load beats a same-cycle completion on that channel.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (Rst || Wr_load[i])
                wr_ptr[i] <= Wr_start[i*AW +: AW];
            else if (done_hit && cur_wr && cur_ch == CHW'(i))
                wr_ptr[i] <= next_ptr(wr_ptr[i], Cmd_len, Wr_start[i*AW +: AW], Wr_max[i*AW +: AW]);
            if (Rst || Rd_load[i])
                rd_ptr[i] <= Rd_start[i*AW +: AW];
            else if (done_hit && !cur_wr && cur_ch == CHW'(i))
                rd_ptr[i] <= next_ptr(rd_ptr[i], Cmd_len, Rd_start[i*AW +: AW], Rd_max[i*AW +: AW]);
        end
    end

    assign Busy   = (state != IDLE);
    assign Cmd_wr = (state == ISSUE) && cur_wr;
    assign Cmd_rd = (state == ISSUE) && !cur_wr;

    always_comb begin
        Wr_grant = '0;
        Rd_grant = '0;
        if (state != IDLE) begin
            if (cur_wr) Wr_grant[cur_ch] = 1'b1;
            else        Rd_grant[cur_ch] = 1'b1;
        end
    end
endmodule
